// File: rtl/rx_byte_to_word_fcs_sn_pkg.sv
// rx_byte_to_word_fcs_sn_pkg
//   Shared definitions for the rx byte-to-word packer:
//   - rx_state_e    : packing FSM state encoding (IDLE / COLLECT / WAIT_FCS)
//   - LANE_COUNT    : byte lanes per output word
//   - FCS_TIMEOUT_TOP_DEFAULT : default FCS wait budget in clk cycles
//   - put_lane()    : write one byte into a lane of a 64-bit word
package rx_byte_to_word_fcs_sn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_WAIT_FCS = 2'd2
  } rx_state_e;

  localparam int LANE_COUNT              = 8;
  localparam int WORD_WIDTH              = LANE_COUNT * 8;
  localparam int FCS_TIMEOUT_TOP_DEFAULT = 1023;

  // Returns word with byte_val placed at bits [8*lane+7 : 8*lane].
  function automatic logic [WORD_WIDTH-1:0] put_lane(
    input logic [WORD_WIDTH-1:0] word,
    input logic [2:0]            lane,
    input logic [7:0]            byte_val
  );
    logic [WORD_WIDTH-1:0] res;
    res = word;
    res[{lane, 3'b000} +: 8] = byte_val;
    return res;
  endfunction

endpackage

// File: rtl/rx_byte_to_word_fcs_sn_if.sv
// rx_byte_to_word_fcs_sn_if
//   Word bus from the byte packer to the rx DMA stage.
//   - data_out       : packed 64-bit word
//   - data_out_valid : one-cycle word strobe
//   - fcs_valid_out  : set together with the final word of a packet
//   - fcs_ok_out     : FCS verdict, meaningful with fcs_valid_out
//   master = packer side (drives), slave = DMA side (receives).
interface rx_byte_to_word_fcs_sn_if
  import rx_byte_to_word_fcs_sn_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  fcs_valid_out;
  logic                  fcs_ok_out;

  modport master (
    output data_out,
    output data_out_valid,
    output fcs_valid_out,
    output fcs_ok_out
  );

  modport slave (
    input data_out,
    input data_out_valid,
    input fcs_valid_out,
    input fcs_ok_out
  );
endinterface

// File: rtl/rx_byte_to_word_fcs_sn_sn_counter.sv
// rx_sn_counter
//   Rx packet sequence number. Advances by one on each plus_one pulse and
//   wraps modulo 2^SN_WIDTH. Independent of the packing FSM.
//   Ports: clk, rstn (sync, active-low), plus_one (in), sn (out, registered).
module rx_sn_counter
  import rx_byte_to_word_fcs_sn_pkg::*;
#(
  parameter int SN_WIDTH = 12
)(
  input  logic                clk,
  input  logic                rstn,
  input  logic                plus_one,
  output logic [SN_WIDTH-1:0] sn
);

  localparam logic [SN_WIDTH-1:0] SN_ONE_C = {{(SN_WIDTH-1){1'b0}}, 1'b1};

  // Sequence-number register; natural binary wrap gives the modulo behaviour.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sn <= {SN_WIDTH{1'b0}};
    end else if (plus_one) begin
      sn <= sn + SN_ONE_C;
    end else begin
      sn <= sn;
    end
  end

endmodule

// File: rtl/rx_byte_to_word_fcs_sn.sv
// rx_byte_to_word_fcs_sn
//   Packs the decoded PSDU byte stream into 64-bit words (byte k -> lane k%8)
//   and delivers them to the rx DMA stage. The last word of a packet is held
//   until the FCS verdict arrives (or a timeout expires) so that it and
//   fcs_valid_out leave in the same cycle. Also hosts the rx sequence number.
//   Ports:
//     clk, rstn          : clock, synchronous active-low reset
//     pkt_start, pkt_len : packet start pulse and PSDU length (FCS included)
//     byte_in(_strobe)   : decoded byte stream
//     fcs_in_strobe, fcs_ok : FCS verdict
//     rx_pkt_sn_plus_one : sequence-number advance pulse from the DMA stage
//     word_if (master)   : data_out / data_out_valid / fcs_valid_out / fcs_ok_out
//     rx_pkt_sn          : current sequence number
//     byte_overrun       : sticky, byte seen outside COLLECT
module rx_byte_to_word_fcs_sn
  import rx_byte_to_word_fcs_sn_pkg::*;
#(
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int SN_WIDTH               = 12,
  parameter int FCS_TIMEOUT_TOP        = FCS_TIMEOUT_TOP_DEFAULT
)(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       pkt_start,
  input  logic [15:0]                pkt_len,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_in_strobe,
  input  logic                       fcs_in_strobe,
  input  logic                       fcs_ok,
  input  logic                       rx_pkt_sn_plus_one,
  rx_byte_to_word_fcs_sn_if.master   word_if,
  output logic [SN_WIDTH-1:0]        rx_pkt_sn,
  output logic                       byte_overrun
);

  localparam int W = C_M00_AXIS_TDATA_WIDTH;

  // Last WAIT_FCS cycle index; the word then appears FCS_TIMEOUT_TOP+1
  // cycles after the last byte strobe.
  localparam logic [15:0] TIMEOUT_LAST_C = 16'(FCS_TIMEOUT_TOP - 1);

  rx_state_e     state_r, state_next_s;
  logic [15:0]   pkt_len_r, pkt_len_next_s;
  logic [15:0]   byte_cnt_r, byte_cnt_next_s, byte_cnt_inc_s;
  logic [W-1:0]  word_buf_r, word_buf_next_s;
  logic [W-1:0]  pending_r, pending_next_s;
  logic [W-1:0]  word_with_byte_s;
  logic          fcs_seen_r, fcs_seen_next_s;
  logic          fcs_ok_seen_r, fcs_ok_seen_next_s;
  logic [15:0]   timer_r, timer_next_s;
  logic          start_s, is_last_s, timeout_s;
  logic          emit_s, emit_fcs_s, emit_ok_s;
  logic [W-1:0]  emit_data_s;

  assign byte_cnt_inc_s   = byte_cnt_r + 16'd1;
  assign is_last_s        = (byte_cnt_inc_s == pkt_len_r);
  assign timeout_s        = (timer_r == TIMEOUT_LAST_C);
  assign word_with_byte_s = put_lane(word_buf_r, byte_cnt_r[2:0], byte_in);
  // Zero-length starts are ignored in IDLE but still abort a running packet.
  assign start_s          = pkt_start && ((state_r != ST_IDLE) || (pkt_len != 16'd0));

  // State register plus packing datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r                <= ST_IDLE;
      pkt_len_r              <= 16'd0;
      byte_cnt_r             <= 16'd0;
      word_buf_r             <= {W{1'b0}};
      pending_r              <= {W{1'b0}};
      fcs_seen_r             <= 1'b0;
      fcs_ok_seen_r          <= 1'b0;
      timer_r                <= 16'd0;
      word_if.data_out       <= {W{1'b0}};
      word_if.data_out_valid <= 1'b0;
      word_if.fcs_valid_out  <= 1'b0;
      word_if.fcs_ok_out     <= 1'b0;
      byte_overrun           <= 1'b0;
    end else begin
      state_r                <= state_next_s;
      pkt_len_r              <= pkt_len_next_s;
      byte_cnt_r             <= byte_cnt_next_s;
      word_buf_r             <= word_buf_next_s;
      pending_r              <= pending_next_s;
      fcs_seen_r             <= fcs_seen_next_s;
      fcs_ok_seen_r          <= fcs_ok_seen_next_s;
      timer_r                <= timer_next_s;
      word_if.data_out       <= emit_data_s;
      word_if.data_out_valid <= emit_s;
      word_if.fcs_valid_out  <= emit_fcs_s;
      word_if.fcs_ok_out     <= emit_ok_s;
      byte_overrun           <= byte_overrun | (byte_in_strobe && (state_r != ST_COLLECT));
    end
  end

  // Next-state logic of the packing FSM.
  always_comb begin
    state_next_s = state_r;
    if (start_s) begin
      state_next_s = (pkt_len != 16'd0) ? ST_COLLECT : ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_next_s = ST_IDLE;
        end
        ST_COLLECT: begin
          if (byte_in_strobe && is_last_s) begin
            // A verdict already in hand (or arriving now) skips WAIT_FCS.
            state_next_s = (fcs_seen_r || fcs_in_strobe) ? ST_IDLE : ST_WAIT_FCS;
          end else begin
            state_next_s = ST_COLLECT;
          end
        end
        ST_WAIT_FCS: begin
          if (fcs_in_strobe || timeout_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_WAIT_FCS;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode and datapath updates of the packing FSM.
  always_comb begin
    emit_s             = 1'b0;
    emit_fcs_s         = 1'b0;
    emit_ok_s          = 1'b0;
    emit_data_s        = {W{1'b0}};
    pkt_len_next_s     = pkt_len_r;
    byte_cnt_next_s    = byte_cnt_r;
    word_buf_next_s    = word_buf_r;
    pending_next_s     = pending_r;
    fcs_seen_next_s    = fcs_seen_r;
    fcs_ok_seen_next_s = fcs_ok_seen_r;
    timer_next_s       = timer_r;
    if (start_s) begin
      // New packet (or abort): drop any partial or pending word silently.
      pkt_len_next_s     = pkt_len;
      byte_cnt_next_s    = 16'd0;
      word_buf_next_s    = {W{1'b0}};
      pending_next_s     = {W{1'b0}};
      fcs_seen_next_s    = 1'b0;
      fcs_ok_seen_next_s = 1'b0;
      timer_next_s       = 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          timer_next_s = 16'd0;
        end
        ST_COLLECT: begin
          if (fcs_in_strobe) begin
            fcs_seen_next_s    = 1'b1;
            fcs_ok_seen_next_s = fcs_ok;
          end else begin
            fcs_seen_next_s    = fcs_seen_r;
          end
          if (byte_in_strobe) begin
            byte_cnt_next_s = byte_cnt_inc_s;
            if (is_last_s) begin
              word_buf_next_s = {W{1'b0}};
              timer_next_s    = 16'd0;
              if (fcs_in_strobe || fcs_seen_r) begin
                emit_s      = 1'b1;
                emit_fcs_s  = 1'b1;
                emit_ok_s   = fcs_in_strobe ? fcs_ok : fcs_ok_seen_r;
                emit_data_s = word_with_byte_s;
              end else begin
                pending_next_s = word_with_byte_s;
              end
            end else if (byte_cnt_r[2:0] == 3'd7) begin
              emit_s          = 1'b1;
              emit_data_s     = word_with_byte_s;
              word_buf_next_s = {W{1'b0}};
            end else begin
              word_buf_next_s = word_with_byte_s;
            end
          end else begin
            byte_cnt_next_s = byte_cnt_r;
          end
        end
        ST_WAIT_FCS: begin
          if (fcs_in_strobe) begin
            emit_s         = 1'b1;
            emit_fcs_s     = 1'b1;
            emit_ok_s      = fcs_ok;
            emit_data_s    = pending_r;
            pending_next_s = {W{1'b0}};
          end else if (timeout_s) begin
            emit_s         = 1'b1;
            emit_fcs_s     = 1'b1;
            emit_ok_s      = 1'b0;
            emit_data_s    = pending_r;
            pending_next_s = {W{1'b0}};
          end else begin
            timer_next_s   = timer_r + 16'd1;
          end
        end
        default: begin
          emit_s = 1'b0;
        end
      endcase
    end
  end

  rx_sn_counter #(
    .SN_WIDTH (SN_WIDTH)
  ) u_sn_counter (
    .clk      (clk),
    .rstn     (rstn),
    .plus_one (rx_pkt_sn_plus_one),
    .sn       (rx_pkt_sn)
  );

endmodule
